// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: turns load-use, branch and data-memory wait requests into
// per-stage write enables and flush strobes, with stall/flush counters and a hung-memory detector.
module pipeline_stall_controller #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             prevent_update_pc,
  input  logic             prevent_update_reg_IF_ID,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             enable_pc,
  output logic             enable_IF_ID,
  output logic             enable_ID_EX,
  output logic             enable_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout_err
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_USE = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ls_c, ms_c, forced_c, stall_c, flush_evt_c;

  // Mealy decode: memory wait beats branch, branch beats load-use.
  always_comb begin
    ls_c          = prevent_update_pc | prevent_update_reg_IF_ID;
    ms_c          = dmem_req & ~dmem_ready;
    forced_c      = ms_c && (wait_q == WAIT_LAST);
    enable_pc     = 1'b1;
    enable_IF_ID  = 1'b1;
    enable_ID_EX  = 1'b1;
    enable_EX_MEM = 1'b1;
    enable_MEM_WB = 1'b1;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    state_d       = ST_RUN;
    wait_d        = '0;
    stall_c       = 1'b0;
    flush_evt_c   = 1'b0;

    if (ms_c) begin
      state_d = ST_MEM_WAIT;
      // A forced release leaves enables high and restarts the wait count.
      if (!forced_c) begin
        enable_pc     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        wait_d        = wait_q + WAIT_W'(1);
        stall_c       = 1'b1;
      end
    end else if (branch_taken) begin
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
      state_d     = ST_FLUSH;
      flush_evt_c = 1'b1;
    end else if (ls_c) begin
      enable_pc    = 1'b0;
      enable_IF_ID = 1'b0;
      flush_ID_EX  = 1'b1;
      state_d      = ST_LOAD_USE;
      stall_c      = 1'b1;
    end

    // Reset holds every stage and clears the front of the pipe.
    if (!arst_n) begin
      enable_pc     = 1'b0;
      enable_IF_ID  = 1'b0;
      enable_ID_EX  = 1'b0;
      enable_EX_MEM = 1'b0;
      enable_MEM_WB = 1'b0;
      flush_IF_ID   = 1'b1;
      flush_ID_EX   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q         <= ST_RUN;
      wait_q          <= '0;
      stall_count     <= '0;
      flush_count     <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (stall_c && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_W'(1);
      if (flush_evt_c && (flush_count != CNT_MAX)) flush_count <= flush_count + CNT_W'(1);
      if (forced_c) mem_timeout_err <= 1'b1;
    end
  end

  assign ctrl_state = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two instances (default and small CNT_W/MEM_TIMEOUT) share
// stimulus; table vectors, directed corner sequences and random traffic against a cycle model.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n, pc, ifid, br, req, rdy;

  logic [4:0]  en_a, en_b;
  logic [1:0]  fl_a, fl_b, st_a, st_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;
  logic        err_a, err_b;

  pipeline_stall_controller #(.CNT_W(16), .MEM_TIMEOUT(64)) dut_a (
    .clk(clk), .arst_n(arst_n),
    .prevent_update_pc(pc), .prevent_update_reg_IF_ID(ifid), .branch_taken(br),
    .dmem_req(req), .dmem_ready(rdy),
    .enable_pc(en_a[4]), .enable_IF_ID(en_a[3]), .enable_ID_EX(en_a[2]),
    .enable_EX_MEM(en_a[1]), .enable_MEM_WB(en_a[0]),
    .flush_IF_ID(fl_a[1]), .flush_ID_EX(fl_a[0]),
    .ctrl_state(st_a), .stall_count(sc_a), .flush_count(fc_a), .mem_timeout_err(err_a)
  );

  pipeline_stall_controller #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .arst_n(arst_n),
    .prevent_update_pc(pc), .prevent_update_reg_IF_ID(ifid), .branch_taken(br),
    .dmem_req(req), .dmem_ready(rdy),
    .enable_pc(en_b[4]), .enable_IF_ID(en_b[3]), .enable_ID_EX(en_b[2]),
    .enable_EX_MEM(en_b[1]), .enable_MEM_WB(en_b[0]),
    .flush_IF_ID(fl_b[1]), .flush_ID_EX(fl_b[0]),
    .ctrl_state(st_b), .stall_count(sc_b), .flush_count(fc_b), .mem_timeout_err(err_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state, one slot per instance.
  int m_timeout[2] = '{64, 4};
  int m_max[2]     = '{65535, 15};
  int m_wait[2], m_stall[2], m_flush[2], m_state[2];
  bit m_err[2];

  logic p_r, p_p, p_f, p_b, p_q, p_y;
  bit   pending = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset(input int i);
    m_wait[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_state[i] = 0; m_err[i] = 1'b0;
  endtask

  // Expected strobes for the current inputs: {pc,IF_ID,ID_EX,EX_MEM,MEM_WB}, {fl_IF_ID,fl_ID_EX}.
  task automatic model_eval(input int i, output logic [4:0] en, output logic [1:0] fl);
    bit ms = req && !rdy;
    if (!arst_n) begin en = 5'h00; fl = 2'b11; end
    else if (ms) begin en = (m_wait[i] == m_timeout[i] - 1) ? 5'h1f : 5'h00; fl = 2'b00; end
    else if (br) begin en = 5'h1f; fl = 2'b11; end
    else if (pc || ifid) begin en = 5'b00111; fl = 2'b01; end
    else begin en = 5'h1f; fl = 2'b00; end
  endtask

  // Advance the model by one clock edge using the inputs held during that cycle.
  task automatic model_update(input int i);
    bit ms = p_q && !p_y;
    if (!p_r) begin
      model_reset(i);
    end else if (ms) begin
      m_state[i] = 2;
      if (m_wait[i] == m_timeout[i] - 1) begin
        m_wait[i] = 0; m_err[i] = 1'b1;
      end else begin
        m_wait[i]++; m_stall[i] = sat_inc(m_stall[i], m_max[i]);
      end
    end else begin
      m_wait[i] = 0;
      if (p_b) begin m_state[i] = 3; m_flush[i] = sat_inc(m_flush[i], m_max[i]); end
      else if (p_p || p_f) begin m_state[i] = 1; m_stall[i] = sat_inc(m_stall[i], m_max[i]); end
      else m_state[i] = 0;
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare both instances to the model.
  task automatic apply(input logic r, input logic p, input logic f, input logic b,
                       input logic q, input logic y);
    logic [4:0] e_en;
    logic [1:0] e_fl;
    @(negedge clk);
    if (pending) begin model_update(0); model_update(1); end
    arst_n = r; pc = p; ifid = f; br = b; req = q; rdy = y;
    p_r = r; p_p = p; p_f = f; p_b = b; p_q = q; p_y = y;
    pending = 1'b1;
    #1;
    model_eval(0, e_en, e_fl);
    check("a_enables", 32'(en_a), 32'(e_en));
    check("a_flushes", 32'(fl_a), 32'(e_fl));
    check("a_state", 32'(st_a), 32'(m_state[0]));
    check("a_stall_count", 32'(sc_a), 32'(m_stall[0]));
    check("a_flush_count", 32'(fc_a), 32'(m_flush[0]));
    check("a_timeout_err", 32'(err_a), 32'(m_err[0]));
    model_eval(1, e_en, e_fl);
    check("b_enables", 32'(en_b), 32'(e_en));
    check("b_flushes", 32'(fl_b), 32'(e_fl));
    check("b_state", 32'(st_b), 32'(m_state[1]));
    check("b_stall_count", 32'(sc_b), 32'(m_stall[1]));
    check("b_flush_count", 32'(fc_b), 32'(m_flush[1]));
    check("b_timeout_err", 32'(err_b), 32'(m_err[1]));
  endtask

  typedef struct {
    logic       p, f, b, q, y;
    logic [4:0] en;
    logic [1:0] fl;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{p:0, f:0, b:0, q:0, y:0, en:5'h1f,    fl:2'b00};
    tbl[1]  = '{p:1, f:0, b:0, q:0, y:0, en:5'b00111, fl:2'b01};
    tbl[2]  = '{p:0, f:1, b:0, q:0, y:0, en:5'b00111, fl:2'b01};
    tbl[3]  = '{p:0, f:0, b:1, q:0, y:0, en:5'h1f,    fl:2'b11};
    tbl[4]  = '{p:1, f:1, b:1, q:0, y:0, en:5'h1f,    fl:2'b11};
    tbl[5]  = '{p:0, f:0, b:0, q:1, y:1, en:5'h1f,    fl:2'b00};
    tbl[6]  = '{p:1, f:0, b:0, q:1, y:1, en:5'b00111, fl:2'b01};
    tbl[7]  = '{p:0, f:0, b:0, q:1, y:0, en:5'h00,    fl:2'b00};
    tbl[8]  = '{p:0, f:0, b:1, q:1, y:0, en:5'h00,    fl:2'b00};
    tbl[9]  = '{p:0, f:0, b:0, q:0, y:1, en:5'h1f,    fl:2'b00};
    tbl[10] = '{p:0, f:0, b:1, q:1, y:1, en:5'h1f,    fl:2'b11};
    tbl[11] = '{p:0, f:1, b:0, q:1, y:0, en:5'h00,    fl:2'b00};

    arst_n = 1'b0; pc = 1'b1; ifid = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    @(posedge clk);
    model_reset(0); model_reset(1);

    // Reset held with a load-use request pending.
    repeat (3) begin
      apply(0, 1, 0, 0, 0, 0);
      check("rst_enables", 32'(en_a), 32'h00);
      check("rst_flushes", 32'(fl_a), 32'h3);
      check("rst_stall_count", 32'(sc_a), 32'd0);
    end
    apply(1, 0, 0, 0, 0, 0);
    check("post_rst_enables", 32'(en_a), 32'h1f);
    check("post_rst_state", 32'(st_a), 32'd0);

    // Single load-use cycle.
    apply(1, 1, 0, 0, 0, 0);
    check("lu_enables", 32'(en_a), 32'h07);
    check("lu_flushes", 32'(fl_a), 32'h1);
    apply(1, 0, 0, 0, 0, 0);
    check("lu_state", 32'(st_a), 32'd1);
    check("lu_stall_count", 32'(sc_a), 32'd1);

    // Five memory-wait cycles then ready.
    apply(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      apply(1, 0, 0, 0, 1, 0);
      check("mw_freeze", 32'(en_a), 32'h00);
    end
    apply(1, 0, 0, 0, 1, 1);
    check("mw_release", 32'(en_a), 32'h1f);
    check("mw_stall_count", 32'(sc_a), 32'd5);
    apply(1, 0, 0, 0, 0, 0);

    // Priority: memory wait suppresses a simultaneous branch and load-use.
    apply(0, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 1, 1, 0);
    check("pri_freeze_en", 32'(en_a), 32'h00);
    check("pri_freeze_fl", 32'(fl_a), 32'h0);
    apply(1, 1, 1, 1, 0, 0);
    check("pri_branch_en", 32'(en_a), 32'h1f);
    check("pri_branch_fl", 32'(fl_a), 32'h3);
    check("pri_flush_before", 32'(fc_a), 32'd0);
    apply(1, 0, 0, 0, 0, 0);
    check("pri_flush_count", 32'(fc_a), 32'd1);
    check("pri_state", 32'(st_a), 32'd3);

    // Timeout on the MEM_TIMEOUT=4 instance.
    apply(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      apply(1, 0, 0, 0, 1, 0);
      check("to_enables", 32'(en_b), (k == 3) ? 32'h1f : 32'h00);
    end
    apply(1, 0, 0, 0, 0, 0);
    check("to_err_set", 32'(err_b), 32'd1);
    check("to_err_default_inst", 32'(err_a), 32'd0);
    apply(1, 0, 0, 1, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    check("to_err_sticky", 32'(err_b), 32'd1);

    // Saturation on the 4-bit counters.
    apply(0, 0, 0, 0, 0, 0);
    repeat (20) apply(1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    check("sat_stall_b", 32'(sc_b), 32'd15);
    check("sat_stall_a", 32'(sc_a), 32'd20);

    // Table vectors from a clean start.
    apply(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      apply(1, tbl[k].p, tbl[k].f, tbl[k].b, tbl[k].q, tbl[k].y);
      check($sformatf("tbl%0d_enables", k), 32'(en_a), 32'(tbl[k].en));
      check($sformatf("tbl%0d_flushes", k), 32'(fl_a), 32'(tbl[k].fl));
    end

    // Random traffic, with occasional resets and long memory stalls.
    for (int k = 0; k < 600; k++) begin
      logic r, q, y;
      r = ($urandom_range(0, 49) != 0);
      q = ($urandom_range(0, 2) == 0);
      y = ($urandom_range(0, 3) == 0);
      apply(r, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) == 0), q, y);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
